// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU control decoder with DEPTH-entry issue FIFO and register-LSH stall
// Optional same-cycle bypass of an empty queue: define ALU_CTRL_BYPASS_EN.
module alu_issue_ctrl #(
   parameter int DEPTH      = 4,
   parameter int CTRL_W     = 4,
   parameter int TAG_W      = 4,
   parameter int LSH_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             opcode,
   input  logic [3:0]             opext,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_W-1:0]      alucont,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   out_illegal,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = (LSH_CYCLES > 1) ? $clog2(LSH_CYCLES) : 1;
   localparam logic [CTRL_W-1:0] LSH_REG    = CTRL_W'(4'b0111);
   localparam logic [SW-1:0]     STALL_LOAD = SW'(LSH_CYCLES - 1);

   logic [CTRL_W-1:0] mem_ctrl [DEPTH];
   logic [TAG_W-1:0]  mem_tag  [DEPTH];
   logic              mem_ill  [DEPTH];

   logic [PW-1:0] wptr, rptr;
   logic [SW-1:0] stall;
   logic [3:0]    dec_code;
   logic          dec_ill;
   logic          bypass, issue, fifo_deq, wr;

   always_comb begin
      dec_code = 4'b0110;
      dec_ill  = 1'b0;
      case (opcode)
         4'b0101: dec_code = 4'b0000;
         4'b1001: dec_code = 4'b0001;
         4'b0001: dec_code = 4'b0010;
         4'b0011: dec_code = 4'b0011;
         4'b0010: dec_code = 4'b0100;
         4'b1011: dec_code = 4'b0101;
         4'b1101: dec_code = 4'b0110;
         4'b1111: dec_code = 4'b1001;
         4'b1000: dec_code = (opext == 4'b0100) ? 4'b0111 : 4'b1000;
         4'b0000: begin
            case (opext)
               4'b0101: dec_code = 4'b0000;
               4'b1001: dec_code = 4'b0001;
               4'b0001: dec_code = 4'b0010;
               4'b0011: dec_code = 4'b0011;
               4'b0010: dec_code = 4'b0100;
               4'b1011: dec_code = 4'b0101;
               4'b1101: dec_code = 4'b0110;
               default: dec_ill  = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
   end

   assign in_ready = (count < CW'(DEPTH)) && !flush;

   always_comb begin
      out_valid   = 1'b0;
      alucont     = '0;
      out_tag     = '0;
      out_illegal = 1'b0;
`ifdef ALU_CTRL_BYPASS_EN
      bypass = (count == '0) && (stall == '0) && in_valid && !flush;
`else
      bypass = 1'b0;
`endif
      if (count != '0) begin
         alucont     = mem_ctrl[rptr];
         out_tag     = mem_tag[rptr];
         out_illegal = mem_ill[rptr];
         out_valid   = (stall == '0);
      end else if (bypass) begin
         alucont     = CTRL_W'(dec_code);
         out_tag     = in_tag;
         out_illegal = dec_ill;
         out_valid   = 1'b1;
      end
   end

   // A bypassed op that the ALU takes this cycle never occupies a FIFO slot.
   assign issue    = out_valid && out_ready && !flush;
   assign fifo_deq = issue && (count != '0);
   assign wr       = in_valid && in_ready && !(bypass && out_ready);

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_ctrl[wptr] <= CTRL_W'(dec_code);
         mem_tag[wptr]  <= in_tag;
         mem_ill[wptr]  <= dec_ill;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         stall <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         stall <= '0;
      end else begin
         if (wr)
            wptr <= wptr + 1'b1;
         if (fifo_deq)
            rptr <= rptr + 1'b1;
         case ({wr, fifo_deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (issue && (alucont == LSH_REG))
            stall <= STALL_LOAD;
         else if (stall != '0)
            stall <= stall - 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl (DEPTH=4, LSH_CYCLES=3)
module tb_alu_issue_ctrl;

   logic       clk, reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [3:0] opcode, opext, in_tag, alucont, out_tag;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;
   logic [8:0] sb [$];

   typedef struct {
      logic [3:0] op;
      logic [3:0] ext;
      logic [3:0] code;
      logic       ill;
   } vec_t;
   vec_t tbl [14];

   alu_issue_ctrl #(.DEPTH(4), .CTRL_W(4), .TAG_W(4), .LSH_CYCLES(3)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .opext(opext), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .alucont(alucont), .out_tag(out_tag),
      .out_illegal(out_illegal), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] ref_dec(input logic [3:0] op, input logic [3:0] ext);
      logic [3:0] k;
      if (op == 4'b1000)
         return {((ext == 4'b0100) ? 4'b0111 : 4'b1000), 1'b0};
      k = (op == 4'b0000) ? ext : op;
      if (op == 4'b0000 && k == 4'b1111)
         return 5'b0110_1;
      case (k)
         4'b0101: return 5'b0000_0;
         4'b1001: return 5'b0001_0;
         4'b0001: return 5'b0010_0;
         4'b0011: return 5'b0011_0;
         4'b0010: return 5'b0100_0;
         4'b1011: return 5'b0101_0;
         4'b1101: return 5'b0110_0;
         4'b1111: return 5'b1001_0;
         default: return 5'b0110_1;
      endcase
   endfunction

   // Scoreboard: every accepted issue handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && !flush && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_issue got code=%h ill=%b tag=%h", alucont, out_illegal, out_tag);
         end else begin
            logic [8:0] e;
            e = sb.pop_front();
            if ({alucont, out_illegal, out_tag} !== e) begin
               errors++;
               $display("FAIL sb_issue got code=%h ill=%b tag=%h expected code=%h ill=%b tag=%h",
                        alucont, out_illegal, out_tag, e[8:5], e[4], e[3:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] ext, input logic [3:0] tag,
                       input logic [3:0] ec, input logic ei);
      int n;
      n = 0;
      opcode = op; opext = ext; in_tag = tag; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      sb.push_back({ec, ei, tag});
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      #1;
      while ((sb.size() != 0 || count != 3'd0) && n < 200) begin
         step();
         n++;
      end
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);
      chk("drain_count", 32'(count), 32'd0);
   endtask

   initial begin
      tbl[0]  = '{4'b0101, 4'b0000, 4'b0000, 1'b0};
      tbl[1]  = '{4'b1001, 4'b0110, 4'b0001, 1'b0};
      tbl[2]  = '{4'b0001, 4'b1111, 4'b0010, 1'b0};
      tbl[3]  = '{4'b0011, 4'b0001, 4'b0011, 1'b0};
      tbl[4]  = '{4'b0010, 4'b0010, 4'b0100, 1'b0};
      tbl[5]  = '{4'b1011, 4'b1010, 4'b0101, 1'b0};
      tbl[6]  = '{4'b1101, 4'b0000, 4'b0110, 1'b0};
      tbl[7]  = '{4'b1111, 4'b0011, 4'b1001, 1'b0};
      tbl[8]  = '{4'b1000, 4'b0100, 4'b0111, 1'b0};
      tbl[9]  = '{4'b1000, 4'b0000, 4'b1000, 1'b0};
      tbl[10] = '{4'b0000, 4'b1111, 4'b0110, 1'b1};
      tbl[11] = '{4'b0111, 4'b0011, 4'b0110, 1'b1};
      tbl[12] = '{4'b0000, 4'b1011, 4'b0101, 1'b0};
      tbl[13] = '{4'b1100, 4'b0101, 4'b0110, 1'b1};

      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      opcode = '0; opext = '0; in_tag = '0;
      step(); step();
      reset = 1'b1;
      #1;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_alucont", 32'(alucont), 32'd0);
      chk("reset_out_tag", 32'(out_tag), 32'd0);
      chk("reset_out_illegal", 32'(out_illegal), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      out_ready = 1'b1;
      for (int i = 0; i < 14; i++)
         send(tbl[i].op, tbl[i].ext, 4'(i), tbl[i].code, tbl[i].ill);
      drain();

      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         logic [4:0] r;
         v = 8'(i);
         r = ref_dec(v[7:4], v[3:0]);
         send(v[7:4], v[3:0], v[3:0], r[4:1], r[0]);
      end
      drain();
      chk("empty_alucont_zero", 32'(alucont), 32'd0);

      // Fill to DEPTH with the ALU stalled, then one extra op must be refused.
      out_ready = 1'b0;
      opcode = 4'b0101; opext = 4'b0000; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_tag = 4'(i);
         #1;
         chk("full_in_ready_before", 32'(in_ready), 32'd1);
         sb.push_back({4'b0000, 1'b0, 4'(i)});
         step();
      end
      in_tag = 4'd4;
      #1;
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      step();
      in_valid = 1'b0;
      chk("full_fifth_dropped", 32'(count), 32'd4);
      chk("full_head_tag", 32'(out_tag), 32'd0);
      drain();

      // Register LSH followed by ADD: two dead cycles after the LSH issues.
      out_ready = 1'b0;
      send(4'b1000, 4'b0100, 4'd5, 4'b0111, 1'b0);
      send(4'b0000, 4'b0101, 4'd6, 4'b0000, 1'b0);
      out_ready = 1'b1;
      #1;
      chk("lsh_t_valid", 32'(out_valid), 32'd1);
      chk("lsh_t_code", 32'(alucont), 32'd7);
      step();
      chk("lsh_t1_valid", 32'(out_valid), 32'd0);
      step();
      chk("lsh_t2_valid", 32'(out_valid), 32'd0);
      step();
      chk("lsh_t3_valid", 32'(out_valid), 32'd1);
      chk("lsh_t3_code", 32'(alucont), 32'd0);
      chk("lsh_t3_tag", 32'(out_tag), 32'd6);
      step();
      drain();

      // Flush with a coincident in_valid and out_ready.
      out_ready = 1'b0;
      send(4'b0101, 4'b0000, 4'd1, 4'b0000, 1'b0);
      send(4'b1001, 4'b0000, 4'd2, 4'b0001, 1'b0);
      send(4'b0001, 4'b0000, 4'd3, 4'b0010, 1'b0);
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      opcode = 4'b0011; in_tag = 4'd9;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      #1;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("flush_input_absent", 32'(count), 32'd0);

      // Asynchronous reset in the middle of a stall with two ops still queued.
      out_ready = 1'b0;
      send(4'b1000, 4'b0100, 4'd1, 4'b0111, 1'b0);
      send(4'b0000, 4'b0101, 4'd2, 4'b0000, 1'b0);
      send(4'b0000, 4'b0101, 4'd3, 4'b0000, 1'b0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("midstall_count", 32'(count), 32'd2);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_count", 32'(count), 32'd0);
      chk("async_reset_valid", 32'(out_valid), 32'd0);
      chk("async_reset_alucont", 32'(alucont), 32'd0);
      chk("async_reset_tag", 32'(out_tag), 32'd0);
      chk("async_reset_illegal", 32'(out_illegal), 32'd0);
      sb.delete();
      step();
      reset = 1'b1;
      send(4'b0101, 4'b0000, 4'd7, 4'b0000, 1'b0);
      chk("post_reset_no_stall", 32'(out_valid), 32'd1);
      drain();

      out_ready = 1'b1;
      opcode = 4'b0101; opext = 4'b0011; in_tag = 4'd8; in_valid = 1'b1;
      sb.push_back({4'b0000, 1'b0, 4'd8});
      #1;
`ifdef ALU_CTRL_BYPASS_EN
      chk("bypass_same_cycle_valid", 32'(out_valid), 32'd1);
      chk("bypass_alucont", 32'(alucont), 32'd0);
      step();
      in_valid = 1'b0;
      chk("bypass_count_stays_0", 32'(count), 32'd0);
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 4'd10;
      sb.push_back({4'b0000, 1'b0, 4'd10});
      #1;
      chk("bypass_hold_valid", 32'(out_valid), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bypass_hold_count", 32'(count), 32'd1);
`else
      chk("no_bypass_same_cycle", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      chk("no_bypass_count", 32'(count), 32'd1);
      chk("no_bypass_next_valid", 32'(out_valid), 32'd1);
`endif
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Parametrised successor to the combinational ALU-control decoder.
- Decodes {opcode, opext} into an ALU control code at enqueue and buffers decoded ops in a DEPTH-entry FIFO.
- Issues ops to the ALU over a valid/ready handshake and enforces a multi-cycle stall after register-shift (LSH) issue.
- Sits between the fetch/decode stage and the ALU.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CTRL_W, 4, alucont width, >= 4; codes are zero-extended.
- TAG_W, 4, width of the sideband tag carried with each op (destination register index).
- LSH_CYCLES, 2, ALU occupancy of a register LSH; >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; empties the FIFO.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  FIFO can accept.
- opcode  in  4  instruction opcode.
- opext  in  4  opcode extension.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head op available to the ALU.
- out_ready  in  1  ALU accepts.
- alucont  out  CTRL_W  head control code.
- out_tag  out  TAG_W  head tag.
- out_illegal  out  1  head op is an undefined encoding.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Decode table (applied at enqueue):
  - I-type opcodes: 0101->0000, 1001->0001, 0001->0010, 0011->0011, 0010->0100, 1011->0101, 1101->0110, 1111->1001.
  - Opcode 1000: opext 0100 -> 0111 (LSH reg); any other opext -> 1000 (LSHI).
  - Opcode 0000 (R-type): opext 0101->0000, 1001->0001, 0001->0010, 0011->0011, 0010->0100, 1011->0101, 1101->0110.
  - Any other R-type opext, and opcodes 0100, 0110, 0111, 1010, 1100, 1110 -> code 0110 with illegal=1.
- Reset (reset=0, asynchronous):
  - FIFO empties; count=0; stall counter=0.
  - out_valid=0, alucont=0, out_tag=0, out_illegal=0.
  - in_ready=1 once reset is released.
  - Reset mid-stall aborts the stall.
- FIFO:
  - in_ready = (count<DEPTH) && !flush.
  - Enqueue on in_valid && in_ready.
  - Dequeue on out_valid && out_ready.
  - Simultaneous enqueue and dequeue when full is not allowed, because in_ready is 0 when full. When not full, simultaneous enq/deq keeps count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: an op enqueued at edge N into an empty FIFO gives out_valid=1 after edge N (registered path, 1 cycle).
- Outputs: alucont, out_tag and out_illegal reflect the head entry. They are 0 when the FIFO is empty.
- out_valid = (count!=0) && (stall==0).
- Stall:
  - When an op with code 0111 is dequeued, the stall counter loads LSH_CYCLES-1.
  - The counter decrements each cycle until 0.
  - While it is non-zero, out_valid=0 and the FIFO may still accept.
  - LSH_CYCLES=1 means no stall.
- Illegal ops are issued normally (not dropped); the downstream stage decides the trap action.
- Flush:
  - Flush=1 at an edge empties the FIFO and clears the stall counter.
  - An in_valid in the same cycle is dropped, and no dequeue occurs.
  - Flush has priority over enqueue and dequeue.
- Handshake: once out_valid=1, the head entry and out_valid stay stable until accepted or flushed.

Optional Feature:
- ALU_CTRL_BYPASS_EN defined:
  - When count==0, stall==0 and in_valid=1, the decoded input is presented combinationally on the outputs with out_valid=1 in the same cycle.
  - If out_ready=1, the op is consumed without being written to the FIFO, and a bypassed LSH still loads the stall counter.
  - If out_ready=0, the op is enqueued normally.
- Undefined: 1-cycle minimum latency as described above; no combinational input-to-output path.

Test Plan:
- Reset release -> count=0, out_valid=0, alucont=0, in_ready=1. Assert reset mid-stall with 2 ops queued -> all outputs 0 immediately, before the next edge.
- Sweep all 256 {opcode, opext} with out_ready=1 -> alucont/out_illegal match the table. Examples: (1000,0100)->0111; (1000,0000)->1000; (0000,1111)->0110 with illegal=1; (0111,x)->illegal=1.
- DEPTH=4, out_ready=0, push 5 ops -> in_ready=0 after the 4th, count=4, 5th not accepted. Release out_ready -> ops exit in order with tags 0,1,2,3.
- LSH_CYCLES=3, queue LSH then ADD, out_ready=1 -> LSH issues at cycle t. out_valid=0 at t+1 and t+2; ADD (0000) issues at t+3.
- Queue 3 ops, then assert flush together with in_valid -> count=0 next cycle, out_valid=0, flushed-cycle input absent.
- ALU_CTRL_BYPASS_EN on, empty FIFO, in_valid=1 with (0101,x), out_ready=1 -> same-cycle out_valid=1, alucont=0000, count stays 0. Repeat with out_ready=0 -> count=1.
